// File: rtl/tlc_pkg.sv
// Shared types for the two-road traffic-light controller: light codes and
// state encodings (fixed values, visible on the phase output).
package tlc_pkg;

  typedef enum logic [1:0] {
    GREEN  = 2'b00,
    YELLOW = 2'b01,
    RED    = 2'b10
  } light_t;

  typedef enum logic [2:0] {
    S_AG   = 3'd0,
    S_AY   = 3'd1,
    S_BG   = 3'd2,
    S_BY   = 3'd3,
    S_WALK = 3'd4
  } tlc_state_t;

endpackage

// File: rtl/traffic_light_fsm_if.sv
// Controller-side signal bundle: tick/sensor inputs, light/phase outputs.
// Pedestrian request/walk signals exist only when TLC_PED_EN is defined.
interface traffic_light_fsm_if;

  logic       tick;
  logic       ta;
  logic       tb;
  logic [1:0] la;
  logic [1:0] lb;
  logic [2:0] phase;
  logic       phase_chg;
`ifdef TLC_PED_EN
  logic       ped_req;
  logic       walk;

  modport master (output tick, ta, tb, ped_req,
                  input  la, lb, phase, phase_chg, walk);
  modport slave  (input  tick, ta, tb, ped_req,
                  output la, lb, phase, phase_chg, walk);
`else
  modport master (output tick, ta, tb,
                  input  la, lb, phase, phase_chg);
  modport slave  (input  tick, ta, tb,
                  output la, lb, phase, phase_chg);
`endif

endinterface

// File: rtl/tick_timer.sv
// Phase timer: counts enabled ticks, saturates at all-ones, synchronous clear
// has priority over counting.
module tick_timer #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (en && (count != '1))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/traffic_light_fsm.sv
// Tick-paced two-road Moore traffic-light controller.
// Optional pedestrian all-red walk phase enabled by defining TLC_PED_EN.
module traffic_light_fsm
  import tlc_pkg::*;
#(
  parameter int unsigned GREEN_TICKS  = 5,
  parameter int unsigned YELLOW_TICKS = 2,
  parameter int unsigned WALK_TICKS   = 4,
  parameter int unsigned CNT_W        = 4
) (
  input logic                 clk,
  input logic                 reset,
  traffic_light_fsm_if.slave  bus
);

  localparam int unsigned MAX_TICKS =
    (GREEN_TICKS > YELLOW_TICKS) ?
      ((GREEN_TICKS > WALK_TICKS) ? GREEN_TICKS : WALK_TICKS) :
      ((YELLOW_TICKS > WALK_TICKS) ? YELLOW_TICKS : WALK_TICKS);

  if (MAX_TICKS > (2 ** CNT_W) - 1) begin : g_cnt_w_check
    $error("CNT_W too narrow for the configured phase durations");
  end

  localparam logic [CNT_W-1:0] G_LAST = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(YELLOW_TICKS - 1);

  tlc_state_t       state, state_next;
  logic [CNT_W-1:0] timer;
  logic             chg;
  logic             ped_pend;

  // Any state change, including recovery from an illegal encoding, restarts the timer.
  assign chg = (state_next != state);

  tick_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .reset (reset),
    .en    (bus.tick),
    .clr   (chg),
    .count (timer)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_AG;
      bus.phase_chg <= 1'b0;
    end else begin
      state         <= state_next;
      bus.phase_chg <= chg;
    end
  end

`ifdef TLC_PED_EN
  localparam logic [CNT_W-1:0] W_LAST = CNT_W'(WALK_TICKS - 1);

  // A new request wins over the clear on walk entry so it is never lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      ped_pend <= 1'b0;
    else if (bus.ped_req)
      ped_pend <= 1'b1;
    else if (chg && (state_next == S_WALK))
      ped_pend <= 1'b0;
  end

  assign bus.walk = (state == S_WALK);
`else
  assign ped_pend = 1'b0;
`endif

  always_comb begin
    state_next = state;
    case (state)
      S_AG:
        if (bus.tick && (timer >= G_LAST) && (!bus.ta || ped_pend))
          state_next = S_AY;
      S_AY:
        if (bus.tick && (timer == Y_LAST))
          state_next = S_BG;
      S_BG:
        if (bus.tick && (timer >= G_LAST) && (!bus.tb || ped_pend))
          state_next = S_BY;
      S_BY:
        if (bus.tick && (timer == Y_LAST))
          state_next = ped_pend ? S_WALK : S_AG;
`ifdef TLC_PED_EN
      S_WALK:
        if (bus.tick && (timer == W_LAST))
          state_next = S_AG;
`endif
      default:
        state_next = S_AG;
    endcase
  end

  always_comb begin
    bus.la = RED;
    bus.lb = RED;
    case (state)
      S_AG:    bus.la = GREEN;
      S_AY:    bus.la = YELLOW;
      S_BG:    bus.lb = GREEN;
      S_BY:    bus.lb = YELLOW;
      default: ;
    endcase
  end

  assign bus.phase = state;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Self-checking bench for traffic_light_fsm: phase-duration reference model
// compared every cycle, plus directed literal checks (TLC_PED_EN aware).
module tb_traffic_light_fsm;

  localparam int G = 5;
  localparam int Y = 2;
  localparam int W = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  bit   ped_drv = 1'b0;

  traffic_light_fsm_if bus();

  traffic_light_fsm #(
    .GREEN_TICKS  (G),
    .YELLOW_TICKS (Y),
    .WALK_TICKS   (W),
    .CNT_W        (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

`ifdef TLC_PED_EN
  assign bus.ped_req = ped_drv;
`endif

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: phase number (0=A green,1=A yellow,2=B green,3=B yellow,
  // 4=walk) and number of ticks already spent in the current phase.
  int m_ph   = 0;
  int m_el   = 0;
  bit m_chg  = 1'b0;
  bit m_pend = 1'b0;

  function automatic logic [1:0] light_a(int ph);
    if (ph == 0) return 2'b00;
    if (ph == 1) return 2'b01;
    return 2'b10;
  endfunction

  function automatic logic [1:0] light_b(int ph);
    if (ph == 2) return 2'b00;
    if (ph == 3) return 2'b01;
    return 2'b10;
  endfunction

  initial forever begin
    int nxt, el;
    @(posedge clk or posedge reset);
    if (reset) begin
      m_ph = 0; m_el = 0; m_chg = 1'b0; m_pend = 1'b0;
    end else begin
      nxt = m_ph;
      el  = m_el + 1;
      if (bus.tick) begin
        case (m_ph)
          0: if (el >= G && (!bus.ta || m_pend)) nxt = 1;
          1: if (el == Y) nxt = 2;
          2: if (el >= G && (!bus.tb || m_pend)) nxt = 3;
          3: if (el == Y) nxt = m_pend ? 4 : 0;
          4: if (el == W) nxt = 0;
          default: nxt = 0;
        endcase
      end
      m_pend = ped_drv || (m_pend && !(nxt == 4 && m_ph != 4));
      m_chg  = (nxt != m_ph);
      if (m_chg) m_el = 0;
      else if (bus.tick) m_el = el;
      m_ph = nxt;
    end
  end

  initial forever begin
    logic mis;
    @(negedge clk);
    checks++;
    mis = (bus.phase !== 3'(m_ph)) || (bus.la !== light_a(m_ph)) ||
          (bus.lb !== light_b(m_ph)) || (bus.phase_chg !== m_chg);
`ifdef TLC_PED_EN
    mis = mis || (bus.walk !== (m_ph == 4));
`endif
    if (mis) begin
      errors++;
      $display("FAIL model t=%0t phase=%0d want %0d la=%b want %b lb=%b want %b chg=%b want %b",
               $time, bus.phase, m_ph, bus.la, light_a(m_ph), bus.lb, light_b(m_ph),
               bus.phase_chg, m_chg);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0d want %0d", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
  endtask

  int exp_seq [15] = '{0,0,0,0,0,1,1,2,2,2,2,2,3,3,0};
  int ped_seq [19] = '{0,0,0,0,0,1,1,2,2,2,2,2,3,3,4,4,4,4,0};

  initial begin
    int chg_at [3];
    int nchg, cnt;

    bus.tick = 1'b0; bus.ta = 1'b0; bus.tb = 1'b0;

    // Reset values, then idle with tick low
    repeat (3) step();
    chk("rst_la", int'(bus.la), 0);
    chk("rst_lb", int'(bus.lb), 2);
    chk("rst_phase", int'(bus.phase), 0);
    chk("rst_chg", int'(bus.phase_chg), 0);
    reset = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (i % 10 == 9) chk("idle_phase", int'(bus.phase), 0);
    end
    chk("idle_chg", int'(bus.phase_chg), 0);

    // Free-running tick, sensors low: 14-cycle period
    do_reset();
    bus.tick = 1'b1;
    for (int k = 0; k < 15; k++) begin
      chk("seq_phase", int'(bus.phase), exp_seq[k]);
      chk("seq_chg", int'(bus.phase_chg),
          (k == 5 || k == 7 || k == 12 || k == 14) ? 1 : 0);
      step();
    end

    // Divider tick every third cycle
    do_reset();
    nchg = 0;
    chg_at = '{-100, -100, -100};
    for (int i = 0; i < 60; i++) begin
      bus.tick = (i % 3 == 0);
      step();
      if (bus.phase_chg === 1'b1 && nchg < 3) begin
        chg_at[nchg] = i;
        nchg++;
      end
    end
    chk("div_ay_clocks", chg_at[1] - chg_at[0], 6);
    chk("div_bg_clocks", chg_at[2] - chg_at[1], 15);

    // Road A sensor holds green for 10 ticks
    do_reset();
    bus.tick = 1'b1;
    for (int n = 1; n <= 11; n++) begin
      bus.ta = (n <= 10);
      step();
      if (n == 10) chk("ta_hold_phase", int'(bus.phase), 0);
      if (n == 11) chk("ta_release_phase", int'(bus.phase), 1);
    end
    bus.ta = 1'b0;

    // Asynchronous reset in B green with timer=3
    do_reset();
    bus.tick = 1'b1;
    repeat (10) step();
    chk("pre_rst_phase", int'(bus.phase), 2);
    #2 reset = 1'b1;
    #1;
    chk("async_la", int'(bus.la), 0);
    chk("async_lb", int'(bus.lb), 2);
    step();
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.phase !== 3'd0) break;
      cnt++;
      step();
    end
    chk("post_rst_green_len", cnt, 5);

`ifdef TLC_PED_EN
    // Pedestrian request with A sensor held high
    do_reset();
    bus.tick = 1'b1; bus.ta = 1'b1; bus.tb = 1'b1;
    ped_drv = 1'b1;
    for (int k = 0; k < 19; k++) begin
      chk("ped_phase", int'(bus.phase), ped_seq[k]);
      if (k >= 14 && k < 18) chk("ped_walk", int'(bus.walk), 1);
      step();
      ped_drv = 1'b0;
    end
    bus.ta = 1'b0; bus.tb = 1'b0;
`endif

    // Randomized traffic, tick pacing and occasional reset
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bus.tick = ($urandom_range(0, 2) != 0);
      bus.ta   = ($urandom_range(0, 3) == 0);
      bus.tb   = ($urandom_range(0, 3) == 0);
      ped_drv  = 1'b0;
`ifdef TLC_PED_EN
      ped_drv  = ($urandom_range(0, 40) == 0);
`endif
      reset    = ($urandom_range(0, 400) == 0);
      step();
    end
    reset = 1'b0;
    ped_drv = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t simulation did not finish, want finish", $time);
    $fatal(1, "watchdog");
  end

endmodule
